axis_hdr_strip: RTL and testbench
=================================

Name: axis_hdr_strip

Overview:
Downstream consumer of axis_hdr_add output: takes AXI-Stream frames whose first beat is a header word and validates that header. Good frames have the header stripped and the payload forwarded unchanged, TLAST preserved. Bad frames are dropped whole. Frame, error and sequence statistics are exported for the PS/ILA.

Parameters:
DATA_WIDTH, 32, stream width in bits; must be >= 32; header fields live in bits [31:0].
MAGIC, 16'hA5A5, expected value of header bits [31:16].

Ports:
clk  in  1  stream clock (100 MHz nominal).
rstn  in  1  asynchronous active-low reset.
s_axis_tdata  in  DATA_WIDTH  input beats (header first, then payload).
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
s_axis_tlast  in  1  last beat of input frame.
m_axis_tdata  out  DATA_WIDTH  payload beats.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  last payload beat.
frame_cnt  out  16  good frames forwarded (TLAST beat accepted downstream side).
err_cnt  out  16  frames dropped (bad magic or runt).
seq_err_cnt  out  16  sequence discontinuities.
last_seq  out  16  sequence field of last accepted good header.

Behaviour:
- Reset (async assert, sync-released use): state=HDR, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, all counters and last_seq=0, seq_valid flag=0. s_axis_tready=1 after reset.
- Header word: [31:16] magic, [15:0] sequence number; bits above 31 ignored.
- Transfer = tvalid && tready on the respective side.
- FSM states: HDR, PAYLOAD, DROP.
- HDR: s_axis_tready=1 (header never needs output space). On transfer:
  - tlast=1 (runt, header-only) -> err_cnt+1, stay HDR, nothing forwarded.
  - magic != MAGIC -> err_cnt+1, go DROP.
  - else last_seq<=seq, go PAYLOAD.
- PAYLOAD: s_axis_tready = !m_axis_tvalid || m_axis_tready (one-entry registered output stage). Accepted beat loads m_axis_tdata/tlast, sets m_axis_tvalid next cycle. Accepted tlast beat -> go HDR.
- DROP: s_axis_tready=1, beats discarded; accepted tlast -> HDR.
- Output register: m_axis_tvalid cleared on output transfer unless refilled the same cycle. Data/tlast held stable while valid && !ready. Full throughput, 1 beat/cycle when m_axis_tready=1.
- Latency: accepted payload beat appears on m_axis one cycle later. The header costs one input cycle, which produces a one-cycle bubble on the output.
- frame_cnt increments on the output transfer with m_axis_tlast=1.
- Counters saturate at 16'hFFFF (no wrap).
- The next header may be accepted in HDR while the final payload beat is still pending in the output register.
- Reset mid-frame: output beat lost, FSM returns to HDR. The next input beat is treated as a header.

Optional Feature:
Macro AXIS_HDR_STRIP_SEQCHK_EN.
- Defined: on each good header, if seq_valid and seq != last_seq+1 (mod 2^16, so 16'hFFFF->16'h0000 is legal), seq_err_cnt+1 (saturating). Frame is still forwarded, and the expected value resyncs to the received seq. The first good header after reset sets seq_valid=1 with no check.
- Not defined: no sequence logic; seq_err_cnt tied to 0. last_seq is still updated.

Test Plan:
- Good frame: header 0xA5A50000 + payload 1,2,3,4 (tlast on 4), m_ready=1 -> m_axis emits exactly 1,2,3,4 with tlast only on 4; frame_cnt=1, err_cnt=0, last_seq=0x0000.
- Bad magic: header 0x12340001 + 3 payload beats -> nothing on m_axis; err_cnt=1. A following good frame (seq 0x0001) is forwarded intact; frame_cnt=1.
- Runt: single beat 0xA5A50005 with tlast -> no output, err_cnt+1, FSM back in HDR. The next frame is parsed correctly.
- Backpressure: 8-beat payload with m_tready toggling 1,0,0,1 pattern -> no beat lost or duplicated, tdata stable while stalled, s_axis_tready=0 whenever output holds an unaccepted beat.
- Sequence (macro defined): headers seq 0xFFFE,0xFFFF,0x0000,0x0005 -> seq_err_cnt=1, last_seq=0x0005. Without the macro -> seq_err_cnt=0.
- Reset mid-payload after 2 of 5 beats: m_axis_tvalid drops to 0 asynchronously, counters=0. A fresh frame with seq 0x0000 is forwarded normally.

Source files
------------

// File: rtl/axis_hdr_strip_if.sv
// axis_hdr_strip_if -- AXI-Stream bundle used on both sides of axis_hdr_strip.
//
// Signals:
//   tdata  [DATA_WIDTH-1:0]  beat data
//   tvalid                   source has a beat
//   tready                   sink can take a beat
//   tlast                    final beat of a frame
// Modports:
//   master  drives tdata/tvalid/tlast, samples tready
//   slave   samples tdata/tvalid/tlast, drives tready
interface axis_hdr_strip_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_hdr_strip.sv
// axis_hdr_strip -- validates and removes the header beat of AXI-Stream frames.
//
// Each incoming frame starts with a header word: [31:16] magic, [15:0]
// sequence number (bits above 31 ignored). Frames with the right magic have
// the header removed and the payload forwarded unchanged through a one-entry
// registered output stage (TLAST preserved). Frames with a bad magic, and
// header-only (runt) frames, are dropped whole and counted.
//
// Optional feature: define AXIS_HDR_STRIP_SEQCHK_EN to enable sequence
// continuity checking (seq_err_cnt). Without it seq_err_cnt reads 0.
//
// Ports:
//   clk          stream clock
//   rstn         asynchronous active-low reset
//   s_axis       input stream (slave modport): header beat, then payload
//   m_axis       output stream (master modport): payload beats only
//   frame_cnt    good frames forwarded (counted on output TLAST transfer)
//   err_cnt      frames dropped (bad magic or runt)
//   seq_err_cnt  sequence discontinuities among good headers
//   last_seq     sequence field of the last accepted good header
// All counters saturate at 16'hFFFF.
module axis_hdr_strip #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [15:0] MAGIC      = 16'hA5A5
) (
  input  logic                   clk,
  input  logic                   rstn,
  axis_hdr_strip_if.slave        s_axis,
  axis_hdr_strip_if.master       m_axis,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            err_cnt,
  output logic [15:0]            seq_err_cnt,
  output logic [15:0]            last_seq
);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                  state;
  state_t                  state_nxt;
  logic                    in_ready;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    load;
  logic                    hdr_good;
  logic                    hdr_bad;
  logic [15:0]             hdr_magic;
  logic [15:0]             hdr_seq;

  logic [DATA_WIDTH-1:0]   data_p1;
  logic                    last_p1;
  logic                    vld_p1;

  assign hdr_magic = s_axis.tdata[31:16];
  assign hdr_seq   = s_axis.tdata[15:0];

  // Headers and dropped beats never need output space; payload beats may
  // enter only when the output register is empty or draining this cycle.
  assign in_ready  = (state == PAYLOAD) ? (!vld_p1 || m_axis.tready) : 1'b1;
  assign in_xfer   = s_axis.tvalid && in_ready;
  assign out_xfer  = vld_p1 && m_axis.tready;

  assign s_axis.tready = in_ready;
  assign m_axis.tdata  = data_p1;
  assign m_axis.tlast  = last_p1;
  assign m_axis.tvalid = vld_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= HDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    hdr_good  = 1'b0;
    hdr_bad   = 1'b0;
    unique case (state)
      HDR: begin
        if (in_xfer) begin
          if (s_axis.tlast) begin
            hdr_bad = 1'b1;           // runt: header with no payload
          end else if (hdr_magic != MAGIC) begin
            hdr_bad   = 1'b1;
            state_nxt = DROP;
          end else begin
            hdr_good  = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (in_xfer) begin
          load = 1'b1;
          if (s_axis.tlast) state_nxt = HDR;
        end
      end
      DROP: begin
        if (in_xfer && s_axis.tlast) state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= s_axis.tdata;
      last_p1 <= s_axis.tlast;
      vld_p1  <= 1'b1;
    end else if (out_xfer) begin
      vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      last_seq  <= '0;
    end else begin
      if (out_xfer && last_p1) frame_cnt <= sat_inc(frame_cnt);
      if (hdr_bad)             err_cnt   <= sat_inc(err_cnt);
      if (hdr_good)            last_seq  <= hdr_seq;
    end
  end

`ifdef AXIS_HDR_STRIP_SEQCHK_EN
  logic        seq_valid;
  logic [15:0] seq_exp;

  // Expected next sequence wraps modulo 2^16, so FFFF -> 0000 is continuous.
  assign seq_exp = last_seq + 16'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_valid   <= 1'b0;
      seq_err_cnt <= '0;
    end else if (hdr_good) begin
      seq_valid <= 1'b1;
      if (seq_valid && (hdr_seq != seq_exp)) seq_err_cnt <= sat_inc(seq_err_cnt);
    end
  end
`else
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_hdr_strip.sv
// tb_axis_hdr_strip -- directed bench for axis_hdr_strip with a frame-level
// model: each sent frame is classified (good / bad magic / runt) and its
// expected payload beats and counter effects are queued; a negedge process
// checks every output transfer, stall stability and input blocking.
module tb_axis_hdr_strip;
  localparam int DW = 32;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axis_hdr_strip_if #(.DATA_WIDTH(DW)) s_if ();
  axis_hdr_strip_if #(.DATA_WIDTH(DW)) m_if ();

  logic [15:0] frame_cnt, err_cnt, seq_err_cnt, last_seq;

  axis_hdr_strip #(.DATA_WIDTH(DW), .MAGIC(16'hA5A5)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .seq_err_cnt (seq_err_cnt),
    .last_seq    (last_seq)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  beat_t       exp_q[$];
  beat_t       log_q[$];
  int          exp_frame = 0;
  int          exp_err = 0;
  int          exp_seqerr = 0;
  logic [15:0] exp_last_seq = 16'h0;
  bit          exp_seq_valid = 1'b0;
  bit          in_payload = 1'b0;
  bit          bp_mode = 1'b0;
  int          bp_phase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_frame     = 0;
    exp_err       = 0;
    exp_seqerr    = 0;
    exp_last_seq  = 16'h0;
    exp_seq_valid = 1'b0;
  endtask

  // Output ready: constant 1, or the repeating 1,0,0,1 pattern.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_if.tready = (bp_phase == 0) || (bp_phase == 3);
        bp_phase    = (bp_phase + 1) % 4;
      end else begin
        m_if.tready = 1'b1;
      end
    end
  end

  // Compare process: inputs are stable from negedge to the next posedge.
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {31'd0, m_if.tvalid, m_if.tlast, m_if.tdata},
              {31'd0, 1'b1, prev_last, prev_data});
      if (in_payload && m_if.tvalid && !m_if.tready)
        check("s_ready_blocked", {63'd0, s_if.tready}, 64'd0);
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h, expected no beat (t=%0t)", m_if.tdata, $time);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", {32'd0, m_if.tdata}, {32'd0, e.data});
          check("out_last", {63'd0, m_if.tlast}, {63'd0, e.last});
          log_q.push_back({m_if.tlast, m_if.tdata});
        end
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = s_if.tready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: beat %0h not accepted after %0d cycles", d, n);
        done = 1'b1;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  // n == 0 sends a header-only (runt) frame; payload beats are base..base+n-1.
  task automatic send_frame(input logic [31:0] hdr, input int n, input logic [31:0] base);
    bit          good;
    logic [15:0] nxt;
    good = (n > 0) && (hdr[31:16] == 16'hA5A5);
    if (!good) begin
      exp_err++;
    end else begin
      exp_frame++;
      nxt = exp_last_seq + 16'd1;
`ifdef AXIS_HDR_STRIP_SEQCHK_EN
      if (exp_seq_valid && hdr[15:0] != nxt) exp_seqerr++;
`endif
      exp_seq_valid = 1'b1;
      exp_last_seq  = hdr[15:0];
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + 32'(i)});
    end
    send_beat(hdr, (n == 0));
    in_payload = good;
    for (int i = 0; i < n; i++) send_beat(base + 32'(i), (i == n - 1));
    in_payload = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"},   {48'd0, frame_cnt},   64'(exp_frame & 16'hFFFF));
    check({tag, "_err_cnt"},     {48'd0, err_cnt},     64'(exp_err & 16'hFFFF));
    check({tag, "_seq_err_cnt"}, {48'd0, seq_err_cnt}, 64'(exp_seqerr & 16'hFFFF));
    check({tag, "_last_seq"},    {48'd0, last_seq},    {48'd0, exp_last_seq});
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    rstn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", {63'd0, m_if.tvalid}, 64'd0);
    check("rst_m_last",  {63'd0, m_if.tlast},  64'd0);
    check("rst_m_data",  {32'd0, m_if.tdata},  64'd0);
    check_counters("rst");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_s_ready", {63'd0, s_if.tready}, 64'd1);

    // Good frame: payload 1..4
    send_frame(32'hA5A5_0000, 4, 32'd1);
    drain();
    check_counters("good");
    check("good_nbeats", 64'(log_q.size()), 64'd4);
    check("good_beat0",  {31'd0, log_q[0]}, {31'd0, 1'b0, 32'd1});
    check("good_beat2",  {31'd0, log_q[2]}, {31'd0, 1'b0, 32'd3});
    check("good_beat3",  {31'd0, log_q[3]}, {31'd0, 1'b1, 32'd4});
    check("good_lit_frame", {48'd0, frame_cnt}, 64'd1);

    // Bad magic dropped, then a good frame
    send_frame(32'h1234_0001, 3, 32'd10);
    drain();
    check("bad_lit_err", {48'd0, err_cnt}, 64'd1);
    send_frame(32'hA5A5_0001, 3, 32'd20);
    drain();
    check_counters("bad");
    check("bad_nbeats", 64'(log_q.size()), 64'd7);
    check("bad_beat6",  {31'd0, log_q[6]}, {31'd0, 1'b1, 32'd22});

    // Runt, then a good frame
    send_frame(32'hA5A5_0005, 0, 32'd0);
    drain();
    check("runt_lit_err",   {48'd0, err_cnt},   64'd2);
    check("runt_lit_frame", {48'd0, frame_cnt}, 64'd2);
    send_frame(32'hA5A5_0002, 2, 32'd30);
    drain();
    check_counters("runt");

    // Backpressure on an 8-beat payload
    bp_mode = 1'b1;
    send_frame(32'hA5A5_0003, 8, 32'd40);
    drain();
    bp_mode = 1'b0;
    check_counters("bp");
    check("bp_nbeats", 64'(log_q.size()), 64'd17);
    check("bp_beat16", {31'd0, log_q[16]}, {31'd0, 1'b1, 32'd47});

    // Reset after 2 of 5 payload beats
    exp_q.push_back({1'b0, 32'd50});
    exp_q.push_back({1'b0, 32'd51});
    send_beat(32'hA5A5_0009, 1'b0);
    in_payload = 1'b1;
    send_beat(32'd50, 1'b0);
    send_beat(32'd51, 1'b0);
    in_payload = 1'b0;
    rstn = 1'b0;
    model_reset();
    #1;
    check("midrst_m_valid", {63'd0, m_if.tvalid}, 64'd0);
    check_counters("midrst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    send_frame(32'hA5A5_0000, 3, 32'd60);
    drain();
    check_counters("postrst");
    check("postrst_lit_frame", {48'd0, frame_cnt}, 64'd1);

    // Sequence continuity across the 16-bit wrap
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    send_frame(32'hA5A5_FFFE, 1, 32'd70);
    send_frame(32'hA5A5_FFFF, 1, 32'd71);
    send_frame(32'hA5A5_0000, 1, 32'd72);
    send_frame(32'hA5A5_0005, 1, 32'd73);
    drain();
    check_counters("seq");
    check("seq_lit_last", {48'd0, last_seq}, 64'h5);
`ifdef AXIS_HDR_STRIP_SEQCHK_EN
    check("seq_lit_err", {48'd0, seq_err_cnt}, 64'd1);
`else
    check("seq_lit_err", {48'd0, seq_err_cnt}, 64'd0);
`endif
    check("seq_lit_frame", {48'd0, frame_cnt}, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
